// File: rtl/ucca_violation_ctrl_pkg.sv
// Shared definitions for the UCCA violation controller: register word offsets,
// STATUS bit positions and the reset-stretch FSM encoding.
package ucca_violation_ctrl_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ASSERT = 1'b1
    } ucca_state_t;

    // Word offsets inside the register window (byte offsets +0, +2, +4, +6).
    localparam logic [1:0] OFF_STATUS   = 2'd0;
    localparam logic [1:0] OFF_FAULT_PC = 2'd1;
    localparam logic [1:0] OFF_COUNT    = 2'd2;
    localparam logic [1:0] OFF_RSVD     = 2'd3;

    localparam int STAT_VALID = 15;
    localparam int STAT_MULTI = 2;
    localparam int STAT_STK   = 1;
    localparam int STAT_RET   = 0;

    function automatic logic [15:0] pack_status(input logic valid, input logic [2:0] bits);
        logic [15:0] v;
        v = 16'h0000;
        v[STAT_VALID] = valid;
        v[STAT_MULTI] = bits[2];
        v[STAT_STK]   = bits[1];
        v[STAT_RET]   = bits[0];
        return v;
    endfunction

endpackage

// File: rtl/ucca_violation_ctrl_reset_stretch.sv
// Reset stretcher: a violation seen in IDLE launches one registered ucca_reset
// pulse of exactly RESET_CYCLES clocks; violations during the pulse are ignored.
module ucca_reset_stretch
    import ucca_violation_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_viol,
    output logic        o_ucca_reset,
    output ucca_state_t o_state
);

    localparam logic [7:0] LOAD = 8'(RESET_CYCLES - 1);

    ucca_state_t r_state;
    logic [7:0]  r_cnt;
    logic        r_ucca_reset;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 8'd0;
            r_ucca_reset <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_viol) begin
                        r_state      <= ST_ASSERT;
                        r_cnt        <= LOAD;
                        r_ucca_reset <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    // Counter reaching zero marks the last high cycle of the pulse.
                    if (r_cnt == 8'd0) begin
                        r_state      <= ST_IDLE;
                        r_ucca_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_ucca_reset <= 1'b0;
                end
            endcase
        end
    end

    assign o_ucca_reset = r_ucca_reset;
    assign o_state      = r_state;

endmodule

// File: rtl/ucca_violation_ctrl.sv
// UCCA violation controller: stretched ucca_reset, sticky cause/PC log on the
// peripheral bus. Define UCCA_VIOL_COUNT_EN to build the saturating event counter.
module ucca_violation_ctrl
    import ucca_violation_ctrl_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'h0170,
    parameter int          RESET_CYCLES = 8
) (
    input  logic        clk,
    input  logic        system_reset,
    input  logic        return_reset,
    input  logic        stack_reset,
    input  logic [15:0] pc,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    output logic [15:0] per_dout,
    output logic        ucca_reset,
    output logic        viol_pending
);

    logic        r_valid;
    logic [2:0]  r_bits;
    logic [15:0] r_fault_pc;

    logic        w_hit;
    logic        w_wr;
    logic        w_rd;
    logic [1:0]  w_off;
    logic        w_viol;
    logic        w_in_assert;
    logic [2:0]  w_bits_sw;
    logic        w_valid_sw;
    logic [2:0]  w_bits_nxt;
    logic        w_valid_nxt;
    logic [15:0] w_pc_nxt;
    logic [15:0] w_count;
    logic        w_unused;
    ucca_state_t w_state;

    ucca_reset_stretch #(
        .RESET_CYCLES(RESET_CYCLES)
    ) u_stretch (
        .i_clk       (clk),
        .i_rst       (system_reset),
        .i_viol      (w_viol),
        .o_ucca_reset(ucca_reset),
        .o_state     (w_state)
    );

    assign w_viol      = return_reset | stack_reset;
    assign w_in_assert = (w_state == ST_ASSERT);
    assign w_off       = per_addr[1:0];
    assign w_hit       = per_en && (per_addr[13:2] == BASE_ADDR[15:3]);
    assign w_wr        = w_hit && (per_we != 2'b00);
    assign w_rd        = w_hit && (per_we == 2'b00);
    assign w_unused    = ^per_din[15:3];

    // Software clear is applied first so that a same-cycle capture overrides it.
    always_comb begin
        w_bits_sw   = r_bits & ~((w_wr && (w_off == OFF_STATUS)) ? per_din[2:0] : 3'b000);
        w_valid_sw  = r_valid && (w_bits_sw != 3'b000);
        w_bits_nxt  = w_bits_sw;
        w_valid_nxt = w_valid_sw;
        w_pc_nxt    = r_fault_pc;
        if (w_viol) begin
            w_bits_nxt  = w_bits_sw | {w_in_assert | w_valid_sw, stack_reset, return_reset};
            w_valid_nxt = 1'b1;
            if (!w_in_assert && !w_valid_sw) begin
                w_pc_nxt = pc;
            end
        end
    end

    always_ff @(posedge clk or posedge system_reset) begin
        if (system_reset) begin
            r_valid    <= 1'b0;
            r_bits     <= 3'b000;
            r_fault_pc <= 16'h0000;
        end else begin
            r_valid    <= w_valid_nxt;
            r_bits     <= w_bits_nxt;
            r_fault_pc <= w_pc_nxt;
        end
    end

`ifdef UCCA_VIOL_COUNT_EN
    logic [15:0] r_count;

    always_ff @(posedge clk or posedge system_reset) begin
        if (system_reset) begin
            r_count <= 16'h0000;
        end else if (w_wr && (w_off == OFF_COUNT)) begin
            r_count <= w_viol ? 16'h0001 : 16'h0000;
        end else if (w_viol && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'h0001;
        end
    end

    assign w_count = r_count;
`else
    assign w_count = 16'h0000;
`endif

    always_comb begin
        per_dout = 16'h0000;
        if (w_rd) begin
            case (w_off)
                OFF_STATUS:   per_dout = pack_status(r_valid, r_bits);
                OFF_FAULT_PC: per_dout = r_fault_pc;
                OFF_COUNT:    per_dout = w_count;
                default:      per_dout = 16'h0000;
            endcase
        end
    end

    assign viol_pending = r_valid;

endmodule
